cpu_timer: RTL and testbench

CPU_TIMER -- requirements
Module: cpu_timer

---
 rtl/cpu_timer.sv | 167 ++++++++++++++++
 tb/tb_cpu_timer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_timer.sv
// cpu_timer: CPU-mapped 16-bit down-counter with an 8-bit prescaler, one-shot or continuous mode.
// Latency: a write takes effect on its clk edge; read data is registered and valid the cycle after cs.
// Backpressure: none. The CPU bus is always accepted, and dout holds its value between reads.
module cpu_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic       we,
  input  logic [2:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       irq
);

  localparam logic [2:0] A_CTRL = 3'd0;
  localparam logic [2:0] A_STAT = 3'd1;
  localparam logic [2:0] A_PRE  = 3'd2;
  localparam logic [2:0] A_RLO  = 3'd3;
  localparam logic [2:0] A_RHI  = 3'd4;
  localparam logic [2:0] A_CLO  = 3'd5;
  localparam logic [2:0] A_CHI  = 3'd6;

  // Control and status state
  logic        en_q, en_d;
  logic        cont_q, cont_d;
  logic        ie_q, ie_d;
  logic        exp_q, exp_d;
  logic [7:0]  pre_q, pre_d;
  logic [7:0]  rlo_q, rlo_d;
  logic [7:0]  rhi_q, rhi_d;

  // Counting state
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  psc_q, psc_d;
  logic [7:0]  chi_q, chi_d;
  logic [7:0]  dout_q, dout_d;

  // Decoded strobes
  logic        wr_stb;
  logic        rd_stb;
  logic        tick;
  logic        expire;
  logic [15:0] reload;

  assign wr_stb = cs & we;
  assign rd_stb = cs & ~we;
  assign reload = {rhi_q, rlo_q};

  // The prescaler is ticking when it has counted up to PRE; PRE=0 ticks every clock.
  assign tick   = en_q & (psc_q == pre_q);
  // Expiry is a tick that finds the counter already at zero.
  assign expire = tick & (cnt_q == 16'd0);

  assign dout = dout_q;
  assign irq  = exp_q & ie_q;

  // Next-state: counting first, then CPU writes so a CTRL write overrides the expiry's EN update.
  always_comb begin
    en_d   = en_q;
    cont_d = cont_q;
    ie_d   = ie_q;
    exp_d  = exp_q;
    pre_d  = pre_q;
    rlo_d  = rlo_q;
    rhi_d  = rhi_q;
    cnt_d  = cnt_q;
    psc_d  = psc_q;
    chi_d  = chi_q;
    dout_d = dout_q;

    // Prescaler runs only while enabled, so clearing EN freezes it in place.
    if (en_q) begin
      if (tick) begin
        psc_d = 8'd0;
      end else begin
        psc_d = psc_q + 8'd1;
      end
    end

    // Counter decrements per tick; at zero it expires and either reloads or stops.
    if (tick) begin
      if (cnt_q != 16'd0) begin
        cnt_d = cnt_q - 16'd1;
      end else begin
        exp_d = 1'b1;
        if (cont_q) begin
          cnt_d = reload;
        end else begin
          en_d = 1'b0;
        end
      end
    end

    // CPU writes. Reload bytes only feed future loads, never the live count.
    if (wr_stb) begin
      case (addr)
        A_CTRL: begin
          en_d   = din[0];
          cont_d = din[1];
          ie_d   = din[2];
          // A fresh enable restarts the whole timebase from the reload value.
          if (!en_q && din[0]) begin
            cnt_d = reload;
            psc_d = 8'd0;
          end
        end
        A_STAT: begin
          // A simultaneous expiry keeps EXP set so no event is lost.
          if (din[0] && !expire) begin
            exp_d = 1'b0;
          end
        end
        A_PRE:   pre_d = din;
        A_RLO:   rlo_d = din;
        A_RHI:   rhi_d = din;
        default: ;
      endcase
    end

    // CPU reads. Reading CLO snapshots the high byte so CLO-then-CHI is coherent.
    if (rd_stb) begin
      case (addr)
        A_CTRL: dout_d = {5'd0, ie_q, cont_q, en_q};
        A_STAT: dout_d = {7'd0, exp_q};
        A_PRE:  dout_d = pre_q;
        A_RLO:  dout_d = rlo_q;
        A_RHI:  dout_d = rhi_q;
        A_CLO: begin
          dout_d = cnt_q[7:0];
          chi_d  = cnt_q[15:8];
        end
        A_CHI:  dout_d = chi_q;
        default: dout_d = 8'h00;
      endcase
    end
  end

  // State registers; reset clears everything so the block sits idle until EN is written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q   <= 1'b0;
      cont_q <= 1'b0;
      ie_q   <= 1'b0;
      exp_q  <= 1'b0;
      pre_q  <= 8'd0;
      rlo_q  <= 8'd0;
      rhi_q  <= 8'd0;
      cnt_q  <= 16'd0;
      psc_q  <= 8'd0;
      chi_q  <= 8'd0;
      dout_q <= 8'd0;
    end else begin
      en_q   <= en_d;
      cont_q <= cont_d;
      ie_q   <= ie_d;
      exp_q  <= exp_d;
      pre_q  <= pre_d;
      rlo_q  <= rlo_d;
      rhi_q  <= rhi_d;
      cnt_q  <= cnt_d;
      psc_q  <= psc_d;
      chi_q  <= chi_d;
      dout_q <= dout_d;
    end
  end

endmodule

// File: tb/tb_cpu_timer.sv
// tb_cpu_timer: directed checks of the cpu_timer register map, timing and corner cases.
// Inputs change on the falling edge; outputs are sampled on the following falling edge.
// The block has no backpressure, so every bus access completes in one cycle.
module tb_cpu_timer;

  localparam logic [2:0] A_CTRL = 3'd0;
  localparam logic [2:0] A_STAT = 3'd1;
  localparam logic [2:0] A_PRE  = 3'd2;
  localparam logic [2:0] A_RLO  = 3'd3;
  localparam logic [2:0] A_RHI  = 3'd4;
  localparam logic [2:0] A_CLO  = 3'd5;
  localparam logic [2:0] A_CHI  = 3'd6;
  localparam logic [2:0] A_NONE = 3'd7;

  logic       clk;
  logic       rst;
  logic       cs;
  logic       we;
  logic [2:0] addr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       irq;

  int total;
  int bad;

  typedef struct {
    logic       cs;
    logic       we;
    logic [2:0] addr;
    logic [7:0] din;
    logic [7:0] exp_dout;
    logic       exp_irq;
  } vec_t;

  vec_t tbl[20];

  cpu_timer dut (
    .clk  (clk),
    .rst  (rst),
    .cs   (cs),
    .we   (we),
    .addr (addr),
    .din  (din),
    .dout (dout),
    .irq  (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%02h, want 0x%02h", nm, act, expv);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    cs = 1'b1; we = 1'b1; addr = a; din = d;
    @(negedge clk);
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] d);
    cs = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    cs = 1'b0;
    d = dout;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] rv;
    total = 0;
    bad   = 0;
    rst = 1'b1; cs = 1'b0; we = 1'b0; addr = 3'd0; din = 8'd0;
    idle(2);
    rst = 1'b0;

    // Reset state
    chk("reset_dout", dout, 8'h00);
    chk("reset_irq", {7'd0, irq}, 8'h00);

    // Register map vectors: {cs, we, addr, din, expected dout, expected irq}
    tbl[0]  = '{1'b1, 1'b0, A_CTRL, 8'h00, 8'h00, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, A_PRE,  8'h5A, 8'h00, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, A_PRE,  8'h00, 8'h5A, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, A_RLO,  8'h34, 8'h5A, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, A_RHI,  8'h12, 8'h5A, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, A_RLO,  8'h00, 8'h34, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, A_RHI,  8'h00, 8'h12, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, A_CTRL, 8'hFC, 8'h12, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, A_CTRL, 8'h00, 8'h04, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, A_CLO,  8'hFF, 8'h04, 1'b0};
    tbl[10] = '{1'b1, 1'b0, A_CLO,  8'h00, 8'h00, 1'b0};
    tbl[11] = '{1'b1, 1'b1, A_CHI,  8'hAA, 8'h00, 1'b0};
    tbl[12] = '{1'b1, 1'b0, A_CHI,  8'h00, 8'h00, 1'b0};
    tbl[13] = '{1'b1, 1'b1, A_NONE, 8'hFF, 8'h00, 1'b0};
    tbl[14] = '{1'b1, 1'b0, A_NONE, 8'h00, 8'h00, 1'b0};
    tbl[15] = '{1'b1, 1'b1, A_STAT, 8'hFF, 8'h00, 1'b0};
    tbl[16] = '{1'b1, 1'b0, A_STAT, 8'h00, 8'h00, 1'b0};
    tbl[17] = '{1'b1, 1'b0, A_PRE,  8'h00, 8'h5A, 1'b0};
    tbl[18] = '{1'b0, 1'b0, A_RLO,  8'h00, 8'h5A, 1'b0};
    tbl[19] = '{1'b1, 1'b1, A_CTRL, 8'h00, 8'h5A, 1'b0};

    for (int i = 0; i < 20; i++) begin
      cs = tbl[i].cs; we = tbl[i].we; addr = tbl[i].addr; din = tbl[i].din;
      @(negedge clk);
      cs = 1'b0; we = 1'b0;
      chk($sformatf("vec%0d_dout", i), dout, tbl[i].exp_dout);
      chk($sformatf("vec%0d_irq", i), {7'd0, irq}, {7'd0, tbl[i].exp_irq});
    end

    // One-shot: PRE=0, reload=3 -> expiry 4 clocks after the enabling edge, then stop.
    do_reset();
    wr(A_PRE, 8'h00); wr(A_RLO, 8'h03); wr(A_RHI, 8'h00); wr(A_CTRL, 8'h05);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("oneshot_irq_k%0d", k), {7'd0, irq}, (k == 4) ? 8'h01 : 8'h00);
    end
    rd(A_CTRL, rv); chk("oneshot_ctrl", rv, 8'h04);
    rd(A_CLO, rv);  chk("oneshot_clo", rv, 8'h00);
    idle(20);
    rd(A_CLO, rv);  chk("oneshot_clo_later", rv, 8'h00);
    rd(A_STAT, rv); chk("oneshot_stat", rv, 8'h01);
    wr(A_STAT, 8'h01);
    idle(10);
    chk("oneshot_no_reexpire", {7'd0, irq}, 8'h00);

    // Continuous with prescale: PRE=2, reload=1 -> expiry every 6 clocks.
    do_reset();
    wr(A_PRE, 8'h02); wr(A_RLO, 8'h01); wr(A_RHI, 8'h00); wr(A_CTRL, 8'h07);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("cont_irq_k%0d", k), {7'd0, irq}, (k == 6) ? 8'h01 : 8'h00);
    end
    wr(A_STAT, 8'h01);
    chk("cont_clear_k7", {7'd0, irq}, 8'h00);
    for (int k = 8; k <= 12; k++) begin
      @(negedge clk);
      chk($sformatf("cont_irq_k%0d", k), {7'd0, irq}, (k == 12) ? 8'h01 : 8'h00);
    end
    wr(A_STAT, 8'h01);
    chk("cont_clear_k13", {7'd0, irq}, 8'h00);
    idle(4);
    // Clear lands on the expiry edge (k=18): set wins.
    wr(A_STAT, 8'h01);
    chk("clr_vs_exp_irq", {7'd0, irq}, 8'h01);
    rd(A_STAT, rv); chk("clr_vs_exp_stat", rv, 8'h01);
    wr(A_STAT, 8'h01);
    chk("cont_clear_k20", {7'd0, irq}, 8'h00);
    idle(3);
    // CTRL write lands on the expiry edge (k=24): EN=0 from write, EXP still set.
    wr(A_CTRL, 8'h04);
    chk("ctrl_vs_exp_irq", {7'd0, irq}, 8'h01);
    rd(A_CTRL, rv); chk("ctrl_vs_exp_ctrl", rv, 8'h04);
    wr(A_STAT, 8'h01);
    idle(12);
    chk("ctrl_vs_exp_stopped", {7'd0, irq}, 8'h00);

    // Freeze on EN=0 and reload-register isolation from the live count.
    do_reset();
    wr(A_PRE, 8'h00); wr(A_RLO, 8'h10); wr(A_CTRL, 8'h01);
    wr(A_CTRL, 8'h00);
    rd(A_CLO, rv); chk("freeze_clo", rv, 8'h0F);
    idle(5);
    rd(A_CLO, rv); chk("freeze_clo_later", rv, 8'h0F);
    wr(A_RLO, 8'h08);
    rd(A_CLO, rv); chk("freeze_clo_after_rlo", rv, 8'h0F);
    wr(A_CTRL, 8'h01);
    rd(A_CLO, rv); chk("reenable_load", rv, 8'h08);
    wr(A_RLO, 8'h30);
    rd(A_CLO, rv); chk("running_rlo_write", rv, 8'h06);

    // Coherent CLO/CHI read across a high-byte rollover.
    do_reset();
    wr(A_PRE, 8'hFF); wr(A_RLO, 8'h00); wr(A_RHI, 8'h01); wr(A_CTRL, 8'h01);
    rd(A_CLO, rv); chk("coh_clo", rv, 8'h00);
    idle(300);
    rd(A_CHI, rv); chk("coh_chi_snapshot", rv, 8'h01);
    rd(A_CLO, rv); chk("coh_clo_after", rv, 8'hFF);
    rd(A_CHI, rv); chk("coh_chi_new", rv, 8'h00);

    // Asynchronous reset mid-count.
    do_reset();
    wr(A_PRE, 8'h00); wr(A_RLO, 8'h02); wr(A_RHI, 8'h00); wr(A_CTRL, 8'h07);
    rd(A_RLO, rv); chk("arst_pre_dout", rv, 8'h02);
    idle(4);
    chk("arst_pre_irq", {7'd0, irq}, 8'h01);
    #2 rst = 1'b1;
    #1;
    chk("arst_async_dout", dout, 8'h00);
    chk("arst_async_irq", {7'd0, irq}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), rv);
      chk($sformatf("arst_reg%0d", a), rv, 8'h00);
    end
    idle(20);
    chk("arst_idle_irq", {7'd0, irq}, 8'h00);
    rd(A_STAT, rv); chk("arst_idle_stat", rv, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
